// File: rtl/interrupt_service_sequencer_pkg.sv
// Shared definitions for the interrupt service sequencer.
// Contents: sequencer state encoding, memory word width and parameter defaults.
package interrupt_service_sequencer_pkg;

  localparam int          WORD_W            = 16;
  localparam int          PC_W_DEFAULT      = 32;
  localparam int          FLAG_W_DEFAULT    = 4;
  localparam int          DRAIN_CYC_DEFAULT = 4;
  localparam logic [31:0] VEC_ADDR_DEFAULT  = 32'h0000_0000;

  typedef enum logic [3:0] {
    IDLE,
    DRAIN,
    PUSH_HI,
    PUSH_LO,
    PUSH_FL,
    VEC_LO,
    VEC_HI,
    LOAD_VEC,
    ISR,
    POP_FL,
    POP_LO,
    POP_HI,
    LOAD_RET
  } state_t;

endpackage

// File: rtl/interrupt_service_sequencer_stack_word_port.sv
// Generic hold-until-ready memory request driver shared by the push, pop and
// vector-fetch states. The caller keeps addr/wdata stable while active is high;
// accept marks the cycle in which memory takes the request.
// Ports:
//   active    in   request is wanted this cycle
//   we        in   1 = write, 0 = read
//   addr      in   word address
//   wdata     in   write data
//   mem_ready in   memory accepts this cycle
//   mem_req   out  request valid toward memory
//   mem_we    out  write enable toward memory
//   mem_addr  out  address toward memory (0 when idle)
//   mem_wdata out  write data toward memory (0 unless writing)
//   accept    out  request completed this cycle
module stack_word_port
  import interrupt_service_sequencer_pkg::*;
(
  input  logic              active,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              accept
);

  // Idle buses are driven to zero so the port is quiet outside a transfer.
  assign mem_req   = active;
  assign mem_we    = active & we;
  assign mem_addr  = active ? addr : 32'h0;
  assign mem_wdata = (active & we) ? wdata : '0;
  assign accept    = active & mem_ready;

endmodule

// File: rtl/interrupt_service_sequencer.sv
// Interrupt entry/exit sequencer. Takes the single-cycle interrupt pulse,
// stalls and drains the pipeline, pushes PC (hi, lo) and flags onto the stack,
// fetches the ISR vector and loads PC. On RTI inside the ISR it pops flags and
// PC in reverse order and restores them.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   intr_req, rti         interrupt pulse, RTI pulse
//   pc_cur, flags_cur     return address and CCR to save
//   sp                    stack pointer (word address)
//   mem_ready, mem_rdata  memory handshake and read data
//   stall_fetch, flush    pipeline control
//   mem_req/we/addr/wdata memory request
//   sp_dec, sp_inc        stack pointer adjust pulses
//   pc_load, pc_value     PC redirect
//   flags_load/value      CCR restore
//   in_isr                high while servicing an interrupt
module interrupt_service_sequencer
  import interrupt_service_sequencer_pkg::*;
#(
  parameter int          PC_W      = PC_W_DEFAULT,
  parameter int          FLAG_W    = FLAG_W_DEFAULT,
  parameter logic [31:0] VEC_ADDR  = VEC_ADDR_DEFAULT,
  parameter int          DRAIN_CYC = DRAIN_CYC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              intr_req,
  input  logic              rti,
  input  logic [PC_W-1:0]   pc_cur,
  input  logic [FLAG_W-1:0] flags_cur,
  input  logic [31:0]       sp,
  input  logic              mem_ready,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              stall_fetch,
  output logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              sp_dec,
  output logic              sp_inc,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_value,
  output logic              flags_load,
  output logic [FLAG_W-1:0] flags_value,
  output logic              in_isr
);

  localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);

  state_t            state, next_state;
  logic [CNT_W-1:0]  drain_cnt;
  logic              pending;
  logic [PC_W-1:0]   pc_cap;
  logic [FLAG_W-1:0] flags_cap;
  logic [WORD_W-1:0] word_lo, word_hi;
  logic [FLAG_W-1:0] flags_rest;

  logic              port_active, port_we, accept;
  logic [31:0]       port_addr;
  logic [WORD_W-1:0] port_wdata;

  stack_word_port u_port (
    .active    (port_active),
    .we        (port_we),
    .addr      (port_addr),
    .wdata     (port_wdata),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .accept    (accept)
  );

  // State register plus the datapath captures. Entry snapshots PC/flags; a
  // request arriving while busy is remembered once and retried from IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      drain_cnt  <= '0;
      pending    <= 1'b0;
      pc_cap     <= '0;
      flags_cap  <= '0;
      word_lo    <= '0;
      word_hi    <= '0;
      flags_rest <= '0;
      in_isr     <= 1'b0;
    end else begin
      state <= next_state;

      if (state == IDLE && next_state == DRAIN) begin
        pc_cap    <= pc_cur;
        flags_cap <= flags_cur;
        pending   <= 1'b0;
      end else if (state != IDLE && intr_req) begin
        pending <= 1'b1;
      end

      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;

      if (accept) begin
        case (state)
          VEC_LO, POP_LO: word_lo    <= mem_rdata;
          VEC_HI, POP_HI: word_hi    <= mem_rdata;
          POP_FL:         flags_rest <= mem_rdata[FLAG_W-1:0];
          default:        ;
        endcase
      end

      if (state == LOAD_VEC)      in_isr <= 1'b1;
      else if (state == LOAD_RET) in_isr <= 1'b0;
    end
  end

  // Next-state and output decode. Everything is held at zero while reset is
  // asserted so an aborted sequence cannot pulse sp_dec/sp_inc or pc_load.
  always_comb begin
    next_state  = state;
    stall_fetch = 1'b0;
    flush       = 1'b0;
    port_active = 1'b0;
    port_we     = 1'b0;
    port_addr   = 32'h0;
    port_wdata  = '0;
    sp_dec      = 1'b0;
    sp_inc      = 1'b0;
    pc_load     = 1'b0;
    pc_value    = '0;
    flags_load  = 1'b0;
    flags_value = '0;

    if (!reset) begin
      stall_fetch = (state != IDLE) && (state != ISR);
      case (state)
        IDLE: begin
          if (intr_req || pending) begin
            flush      = 1'b1;
            next_state = DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) next_state = PUSH_HI;
        end
        PUSH_HI, PUSH_LO, PUSH_FL: begin
          port_active = 1'b1;
          port_we     = 1'b1;
          port_addr   = sp;
          if (state == PUSH_HI)      port_wdata = pc_cap[PC_W-1:WORD_W];
          else if (state == PUSH_LO) port_wdata = pc_cap[WORD_W-1:0];
          else                       port_wdata = {{(WORD_W-FLAG_W){1'b0}}, flags_cap};
          if (accept) begin
            sp_dec     = 1'b1;
            next_state = (state == PUSH_HI) ? PUSH_LO :
                         (state == PUSH_LO) ? PUSH_FL : VEC_LO;
          end
        end
        VEC_LO, VEC_HI: begin
          port_active = 1'b1;
          port_addr   = (state == VEC_LO) ? VEC_ADDR : VEC_ADDR + 32'd1;
          if (accept) next_state = (state == VEC_LO) ? VEC_HI : LOAD_VEC;
        end
        LOAD_VEC: begin
          pc_load    = 1'b1;
          pc_value   = PC_W'({word_hi, word_lo});
          next_state = ISR;
        end
        ISR: begin
          if (rti) begin
            flush      = 1'b1;
            next_state = POP_FL;
          end
        end
        POP_FL, POP_LO, POP_HI: begin
          // Stack pointer points at the next free slot, so pops read sp+1.
          port_active = 1'b1;
          port_addr   = sp + 32'd1;
          if (accept) begin
            sp_inc     = 1'b1;
            next_state = (state == POP_FL) ? POP_LO :
                         (state == POP_LO) ? POP_HI : LOAD_RET;
          end
        end
        LOAD_RET: begin
          pc_load     = 1'b1;
          pc_value    = PC_W'({word_hi, word_lo});
          flags_load  = 1'b1;
          flags_value = flags_rest;
          next_state  = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_service_sequencer.sv
// Directed self-checking bench for interrupt_service_sequencer.
module tb_interrupt_service_sequencer;

  logic        clk = 1'b0;
  logic        reset, intr_req, rti, mem_ready;
  logic [31:0] pc_cur;
  logic [3:0]  flags_cur;
  logic [31:0] sp;
  logic [15:0] mem_rdata;
  logic        stall_fetch, flush, mem_req, mem_we, sp_dec, sp_inc;
  logic        pc_load, flags_load, in_isr;
  logic [31:0] mem_addr, pc_value;
  logic [15:0] mem_wdata;
  logic [3:0]  flags_value;

  logic        sp_force;
  logic [31:0] sp_init;
  logic [15:0] vec_lo_word, vec_hi_word;
  logic [15:0] stack_mem [0:4095];

  int assert_count = 0;
  int fail_count   = 0;

  always #5 clk = ~clk;

  interrupt_service_sequencer #(
    .PC_W(32), .FLAG_W(4), .VEC_ADDR(32'h0), .DRAIN_CYC(4)
  ) dut (
    .clk(clk), .reset(reset), .intr_req(intr_req), .rti(rti),
    .pc_cur(pc_cur), .flags_cur(flags_cur), .sp(sp),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_fetch(stall_fetch), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .sp_dec(sp_dec), .sp_inc(sp_inc),
    .pc_load(pc_load), .pc_value(pc_value),
    .flags_load(flags_load), .flags_value(flags_value),
    .in_isr(in_isr)
  );

  // Stack pointer owned by the CPU: follows the sequencer's adjust pulses.
  always @(posedge clk) begin
    if (sp_force)    sp <= sp_init;
    else if (sp_dec) sp <= sp - 32'd1;
    else if (sp_inc) sp <= sp + 32'd1;
  end

  // Data memory: vector words at 0/1, stack storage everywhere else.
  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ready) stack_mem[mem_addr[11:0]] <= mem_wdata;
  end

  always_comb begin
    mem_rdata = 16'h0;
    if (mem_addr == 32'd0)      mem_rdata = vec_lo_word;
    else if (mem_addr == 32'd1) mem_rdata = vec_hi_word;
    else                        mem_rdata = stack_mem[mem_addr[11:0]];
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic intr, input logic rt, input logic rdy);
    @(negedge clk);
    intr_req  = intr;
    rti       = rt;
    mem_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkPush(input string tag, input logic [31:0] a, input logic [15:0] d);
    checkOutput({tag, "_req"}, 32'(mem_req), 32'd1);
    checkOutput({tag, "_we"}, 32'(mem_we), 32'd1);
    checkOutput({tag, "_addr"}, mem_addr, a);
    checkOutput({tag, "_wdata"}, 32'(mem_wdata), 32'(d));
    checkOutput({tag, "_spdec"}, 32'(sp_dec), 32'd1);
    checkOutput({tag, "_stall"}, 32'(stall_fetch), 32'd1);
  endtask

  task automatic checkRead(input string tag, input logic [31:0] a, input logic pop);
    checkOutput({tag, "_req"}, 32'(mem_req), 32'd1);
    checkOutput({tag, "_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_addr"}, mem_addr, a);
    checkOutput({tag, "_spinc"}, 32'(sp_inc), 32'(pop));
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_req"}, 32'(mem_req), 32'd0);
    checkOutput({tag, "_stall"}, 32'(stall_fetch), 32'd0);
    checkOutput({tag, "_pcload"}, 32'(pc_load), 32'd0);
  endtask

  task automatic runDrain(input string tag);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput({tag, "_drain_stall"}, 32'(stall_fetch), 32'd1);
      checkOutput({tag, "_drain_req"}, 32'(mem_req), 32'd0);
    end
  endtask

  task automatic runVector(input string tag);
    applyStimulus(1'b0, 1'b0, 1'b1); checkRead({tag, "_vlo"}, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1); checkRead({tag, "_vhi"}, 32'h1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput({tag, "_pcload"}, 32'(pc_load), 32'd1);
    checkOutput({tag, "_pcvec"}, pc_value, 32'h0000_0200);
  endtask

  task automatic runReturn(input string tag, input logic [31:0] pc_exp, input logic [3:0] fl_exp);
    applyStimulus(1'b0, 1'b0, 1'b1); checkRead({tag, "_popfl"}, 32'h7FD, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1); checkRead({tag, "_poplo"}, 32'h7FE, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1); checkRead({tag, "_pophi"}, 32'h7FF, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput({tag, "_retload"}, 32'(pc_load), 32'd1);
    checkOutput({tag, "_retpc"}, pc_value, pc_exp);
    checkOutput({tag, "_flload"}, 32'(flags_load), 32'd1);
    checkOutput({tag, "_flval"}, 32'(flags_value), 32'(fl_exp));
  endtask

  initial begin
    reset = 1'b1; intr_req = 1'b0; rti = 1'b0; mem_ready = 1'b1;
    pc_cur = 32'h0000_0123; flags_cur = 4'b1010;
    sp_force = 1'b1; sp_init = 32'h7FF;
    vec_lo_word = 16'h0200; vec_hi_word = 16'h0000;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    checkQuiet("rst");
    checkOutput("rst_flush", 32'(flush), 32'd0);
    checkOutput("rst_inisr", 32'(in_isr), 32'd0);
    reset = 1'b0; sp_force = 1'b0;

    // Test 1: entry with memory always ready
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t1_flush", 32'(flush), 32'd1);
    checkOutput("t1_stall0", 32'(stall_fetch), 32'd0);
    runDrain("t1");
    applyStimulus(1'b0, 1'b0, 1'b1); checkPush("t1_phi", 32'h7FF, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b1); checkPush("t1_plo", 32'h7FE, 16'h0123);
    applyStimulus(1'b0, 1'b0, 1'b1); checkPush("t1_pfl", 32'h7FD, 16'h000A);
    runVector("t1");
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t1_inisr", 32'(in_isr), 32'd1);
    checkOutput("t1_isr_stall", 32'(stall_fetch), 32'd0);
    checkOutput("t1_sp", sp, 32'h7FC);

    // Test 2: return
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("t2_flush", 32'(flush), 32'd1);
    runReturn("t2", 32'h0000_0123, 4'b1010);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t2_inisr", 32'(in_isr), 32'd0);
    checkQuiet("t2_idle");
    checkOutput("t2_sp", sp, 32'h7FF);

    // Test 3: memory back-pressure during PUSH_LO
    pc_cur = 32'hABCD_1234; flags_cur = 4'b0101;
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t3_flush", 32'(flush), 32'd1);
    runDrain("t3");
    applyStimulus(1'b0, 1'b0, 1'b1); checkPush("t3_phi", 32'h7FF, 16'hABCD);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("t3_hold_req", 32'(mem_req), 32'd1);
      checkOutput("t3_hold_addr", mem_addr, 32'h7FE);
      checkOutput("t3_hold_wdata", 32'(mem_wdata), 32'h1234);
      checkOutput("t3_hold_spdec", 32'(sp_dec), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1); checkPush("t3_plo", 32'h7FE, 16'h1234);
    applyStimulus(1'b0, 1'b0, 1'b1); checkPush("t3_pfl", 32'h7FD, 16'h0005);
    runVector("t3");
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t3_inisr", 32'(in_isr), 32'd1);
    checkOutput("t3_sp", sp, 32'h7FC);

    // Test 4: request during ISR is pended, a third one is dropped
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkQuiet("t4_isr_a");
    applyStimulus(1'b0, 1'b0, 1'b1); checkQuiet("t4_isr_b");
    applyStimulus(1'b0, 1'b0, 1'b1); checkQuiet("t4_isr_c");
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("t4_rti_flush", 32'(flush), 32'd1);
    pc_cur = 32'h0000_0456; flags_cur = 4'b0011;
    applyStimulus(1'b0, 1'b0, 1'b1); checkRead("t4_popfl", 32'h7FD, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1); checkRead("t4_poplo", 32'h7FE, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1); checkRead("t4_pophi", 32'h7FF, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t4_retpc", pc_value, 32'hABCD_1234);
    checkOutput("t4_retfl", 32'(flags_value), 32'h5);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t4_reentry_flush", 32'(flush), 32'd1);
    checkOutput("t4_reentry_inisr", 32'(in_isr), 32'd0);
    runDrain("t4");
    applyStimulus(1'b0, 1'b0, 1'b1); checkPush("t4_phi", 32'h7FF, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b1); checkPush("t4_plo", 32'h7FE, 16'h0456);
    applyStimulus(1'b0, 1'b0, 1'b1); checkPush("t4_pfl", 32'h7FD, 16'h0003);
    runVector("t4");
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("t4_rti2_flush", 32'(flush), 32'd1);
    runReturn("t4b", 32'h0000_0456, 4'b0011);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkQuiet("t4_dropped");
      checkOutput("t4_dropped_flush", 32'(flush), 32'd0);
    end

    // Test 5: reset in PUSH_FL aborts without SP or PC update
    pc_cur = 32'h0000_0999; flags_cur = 4'hF;
    applyStimulus(1'b1, 1'b0, 1'b1);
    runDrain("t5");
    applyStimulus(1'b0, 1'b0, 1'b1); checkPush("t5_phi", 32'h7FF, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b1); checkPush("t5_plo", 32'h7FE, 16'h0999);
    applyStimulus(1'b0, 1'b0, 1'b1); checkPush("t5_pfl", 32'h7FD, 16'h000F);
    reset = 1'b1; #1;
    checkOutput("t5_rst_req", 32'(mem_req), 32'd0);
    checkOutput("t5_rst_spdec", 32'(sp_dec), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkQuiet("t5_after");
    checkOutput("t5_after_inisr", 32'(in_isr), 32'd0);
    checkOutput("t5_sp", sp, 32'h7FD);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1); checkQuiet("t5_idle");

    // Test 6: rti in IDLE ignored; intr_req + rti together in ISR
    sp_force = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1);
    sp_force = 1'b0;
    checkQuiet("t6_rti_idle");
    checkOutput("t6_rti_idle_flush", 32'(flush), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkQuiet("t6_still_idle");
    checkOutput("t6_sp", sp, 32'h7FF);
    pc_cur = 32'h0000_0789; flags_cur = 4'b0001;
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t6_flush", 32'(flush), 32'd1);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t6_pcload", 32'(pc_load), 32'd1);
    checkOutput("t6_pcvec", pc_value, 32'h0000_0200);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t6_both_flush", 32'(flush), 32'd1);
    checkOutput("t6_both_inisr", 32'(in_isr), 32'd1);
    runReturn("t6", 32'h0000_0789, 4'b0001);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t6_reentry_flush", 32'(flush), 32'd1);
    runDrain("t6");
    applyStimulus(1'b0, 1'b0, 1'b1); checkPush("t6_phi", 32'h7FF, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
